otp_stream_decipher: RTL and testbench
======================================

OTP_STREAM_DECIPHER -- requirements
Module: otp_stream_decipher

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the width of one ciphertext/plaintext symbol in bits.
REQ-002 SHALL have parameter MSG_LEN, default 4, giving the number of symbols per message.
REQ-003 SHALL have parameter SEED_W, default 16, giving the keystream LFSR width; DATA_W <= SEED_W.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request that loads the seed and begins a message.
REQ-007 SHALL have port seed, input, SEED_W bits: the shared key seed, sampled when start is accepted.
REQ-008 SHALL have port in_valid, input, 1 bit: the ciphertext symbol is valid.
REQ-009 SHALL have port in_data, input, DATA_W bits: the ciphertext symbol.
REQ-010 SHALL have port in_ready, output, 1 bit: the block can accept a symbol.
REQ-011 SHALL have port out_valid, output, 1 bit: the plaintext symbol is valid.
REQ-012 SHALL have port out_data, output, DATA_W bits: the plaintext symbol, registered.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream side accepts the plaintext symbol.
REQ-014 SHALL have port busy, output, 1 bit: high while in the RUN state.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle pulse marking message complete.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE on the output handshake of symbol MSG_LEN-1.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 SHALL ignore start while in RUN or DONE, with no reload and no counter change.
REQ-018 SHALL load the LFSR with seed on start; a seed of all zeros SHALL load 16'hACE1 (low SEED_W bits) instead.
REQ-019 SHALL use a Galois right-shift LFSR with feedback mask 16'hB400; one step is: lsb = lfsr[0]; lfsr = lfsr >> 1; if lsb, lfsr ^= mask.
REQ-020 SHALL take the key symbol as lfsr[DATA_W-1:0] before advancing.
REQ-021 SHALL advance the LFSR exactly DATA_W steps per accepted input symbol, all within the same cycle.
REQ-022 SHALL register out_data as in_data XOR the key symbol on input handshake (in_valid && in_ready), and set out_valid=1 in the next cycle.
- Latency: one clock from input handshake to out_valid.
REQ-023 SHALL drive in_ready = (state==RUN) && (in_cnt < MSG_LEN) && (!out_valid || out_ready).
- Simultaneous output handshake and new input in the same cycle SHALL sustain one symbol per clock.
REQ-024 SHALL hold out_valid and out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid on an output handshake when there is no simultaneous input handshake.
REQ-026 SHALL keep in_cnt and out_cnt counters of width clog2(MSG_LEN+1).
- Both clear on start.
- in_cnt increments on input handshake and saturates at MSG_LEN, which blocks further input.
- out_cnt increments on output handshake.
REQ-027 SHALL deassert in_ready in IDLE and DONE, and SHALL not change out_valid there except through a pending output handshake.
REQ-028 SHALL assert done only in DONE; busy = (state==RUN).
REQ-029 SHALL ignore in_valid when in_ready=0, with no state or key change.

Reset
REQ-030 SHALL on reset=1 immediately force state=IDLE, out_valid=0, out_data=0, in_ready=0, busy=0, done=0, both counters=0 and lfsr=0, independent of the clock.
REQ-031 SHALL, when reset asserts mid-message, discard any pending symbol and require a new start after reset release.

Verification
REQ-032 SHALL be verified by these directed scenarios:
- Seed 16'h1234, start, in_data 8'h00 with out_ready=1 -> out_data 8'h34 one clock later.
- Seed 16'h0000, start, in_data 8'hFF -> out_data 8'h1E (key 8'hE1).
- Round trip: MSG_LEN=4 symbols "ABCD" encrypted by the reference model with seed 16'hBEEF, fed back-to-back -> output 8'h41,8'h42,8'h43,8'h44 on four consecutive cycles; done pulses exactly once, one cycle after the last output handshake.
- Backpressure: out_ready=0 for 5 cycles mid-message -> in_ready=0 and out_data stable throughout; no symbol lost or duplicated after release.
- Start pulsed during RUN -> ignored; the key sequence continues unchanged.
- Reset asserted after 2 of 4 symbols -> all outputs 0 asynchronously; a new start with the same seed reproduces the first key symbol.

Source files
------------

// File: rtl/otp_stream_decipher.sv
// One-time-pad stream decipher: XORs each ciphertext symbol with a key symbol
// drawn from a Galois LFSR seeded per message, with a valid/ready pipeline stage.
module otp_stream_decipher #(
   parameter int DATA_W  = 8,
   parameter int MSG_LEN = 4,
   parameter int SEED_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [SEED_W-1:0] seed,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(MSG_LEN + 1);
   localparam logic [SEED_W-1:0] LFSR_MASK = SEED_W'(16'hB400);
   localparam logic [SEED_W-1:0] ZERO_SEED_SUBST = SEED_W'(16'hACE1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [SEED_W-1:0]  lfsr_q, lfsr_d;
   logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               in_hs, out_hs;

   // Advance the keystream by one full symbol (DATA_W single-bit steps).
   function automatic logic [SEED_W-1:0] lfsr_adv(input logic [SEED_W-1:0] s);
      logic [SEED_W-1:0] r;
      r = s;
      for (int i = 0; i < DATA_W; i++) begin
         if (r[0]) r = (r >> 1) ^ LFSR_MASK;
         else      r = r >> 1;
      end
      return r;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         lfsr_q      <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN:  if (out_hs && (out_cnt_q == CNT_W'(MSG_LEN - 1))) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lfsr_d      = lfsr_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (out_hs) out_cnt_d = out_cnt_q + CNT_W'(1);
      if (state_q == IDLE && start) begin
         lfsr_d    = (seed == '0) ? ZERO_SEED_SUBST : seed;
         in_cnt_d  = '0;
         out_cnt_d = '0;
      end else if (in_hs) begin
         lfsr_d   = lfsr_adv(lfsr_q);
         in_cnt_d = in_cnt_q + CNT_W'(1);
      end
      // A new input refills the output slot even while the old symbol drains.
      if (in_hs) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ lfsr_q[DATA_W-1:0];
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      in_ready = (state_q == RUN) && (in_cnt_q < CNT_W'(MSG_LEN)) &&
                 (!out_valid_q || out_ready);
      busy     = (state_q == RUN);
      done     = (state_q == DONE);
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_otp_stream_decipher.sv
// Directed bench for otp_stream_decipher: seeds, round trip, backpressure,
// ignored start and asynchronous reset mid-message.
module tb_otp_stream_decipher;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] seed;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        busy;
   logic        done;

   int n_chk = 0;
   int n_bad = 0;

   logic [7:0] plain [4];
   logic [7:0] cipher [4];

   otp_stream_decipher #(.DATA_W(8), .MSG_LEN(4), .SEED_W(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference keystream step: 8 Galois right shifts with mask B400.
   function automatic logic [15:0] ref_adv(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      tick();
   endtask

   task automatic do_start(input logic [15:0] s);
      start = 1'b1;
      seed  = s;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [15:0] s;
      int done_cnt;
      reset = 1'b1; start = 1'b0; seed = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      #20;
      reset = 1'b0;
      tick();

      plain[0] = 8'h41; plain[1] = 8'h42; plain[2] = 8'h43; plain[3] = 8'h44;
      s = 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
         cipher[i] = plain[i] ^ s[7:0];
         s = ref_adv(s);
      end

      // Seed 1234: first key is the seed low byte.
      do_start(16'h1234);
      chk("s1_busy", busy, 1);
      chk("s1_in_ready", in_ready, 1);
      in_valid = 1'b1; in_data = 8'h00;
      tick();
      in_valid = 1'b0;
      chk("s1_out_valid", out_valid, 1);
      chk("s1_out_data", out_data, 8'h34);

      // Zero seed substitutes ACE1.
      do_reset();
      do_start(16'h0000);
      in_valid = 1'b1; in_data = 8'hFF;
      tick();
      in_valid = 1'b0;
      chk("s2_out_data", out_data, 8'h1E);

      // Round trip back-to-back with done pulse timing.
      do_reset();
      do_start(16'hBEEF);
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = cipher[i];
         tick();
         chk($sformatf("rt_valid%0d", i), out_valid, 1);
         chk($sformatf("rt_data%0d", i), out_data, plain[i]);
         if (done) done_cnt++;
      end
      in_valid = 1'b0;
      chk("rt_in_ready_sat", in_ready, 0);
      tick();
      chk("rt_done_pulse", done, 1);
      chk("rt_out_valid_clr", out_valid, 0);
      if (done) done_cnt++;
      tick();
      chk("rt_done_low", done, 0);
      chk("rt_idle", busy, 0);
      if (done) done_cnt++;
      chk("rt_done_count", done_cnt, 1);

      // Backpressure for 5 cycles after the first symbol.
      do_reset();
      do_start(16'hBEEF);
      in_valid = 1'b1; in_data = cipher[0];
      tick();
      chk("bp_data0", out_data, plain[0]);
      out_ready = 1'b0; in_data = cipher[1];
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
         tick();
         chk($sformatf("bp_hold%0d", i), out_data, plain[0]);
         chk($sformatf("bp_valid%0d", i), out_valid, 1);
      end
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         in_data = cipher[i];
         tick();
         chk($sformatf("bp_data%0d", i), out_data, plain[i]);
      end
      in_valid = 1'b0;

      // Start during RUN is ignored.
      do_reset();
      do_start(16'hBEEF);
      in_valid = 1'b1; in_data = cipher[0];
      tick();
      chk("ig_data0", out_data, plain[0]);
      start = 1'b1; seed = 16'h1234; in_data = cipher[1];
      tick();
      start = 1'b0;
      chk("ig_data1", out_data, plain[1]);
      in_data = cipher[2];
      tick();
      chk("ig_data2", out_data, plain[2]);
      chk("ig_busy", busy, 1);
      in_valid = 1'b0;

      // Asynchronous reset after two symbols.
      do_reset();
      do_start(16'hBEEF);
      in_valid = 1'b1; in_data = cipher[0];
      tick();
      in_data = cipher[1];
      tick();
      chk("ar_pre_data", out_data, plain[1]);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_out_data", out_data, 0);
      chk("ar_in_ready", in_ready, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      #1;
      reset = 1'b0;
      tick();
      chk("ar_idle_ready", in_ready, 0);
      do_start(16'hBEEF);
      in_valid = 1'b1; in_data = cipher[0];
      tick();
      in_valid = 1'b0;
      chk("ar_restart_data", out_data, plain[0]);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
